// File: rtl/div_unit_pkg.sv
// div_unit shared definitions: state encodings
// and request/sign flag constants.
package div_unit_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_t;

  localparam logic DIV_START  = 1'b1;
  localparam logic DIV_SIGNED = 1'b1;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between execute and the
// divider; master = pipeline, slave = div_unit.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_W
);
  logic              start;
  logic              is_signed;
  logic              cancel;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output start, is_signed, cancel,
    output dividend, divisor,
    input  busy, valid, quotient, remainder
  );

  modport slave (
    input  start, is_signed, cancel,
    input  dividend, divisor,
    output busy, valid, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU,
// one quotient bit per cycle, feeding HI/LO.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  div_state_t        state;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic              neg_q;
  logic              neg_r;
  logic              busy_q;
  logic              valid_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rmd_q;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic [DATA_W:0]   part;
  logic [DATA_W-1:0] sub;
  logic              take;
  logic [DATA_W-1:0] q_nxt;
  logic [DATA_W-1:0] r_nxt;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  assign a_neg = (bus.is_signed == DIV_SIGNED)
               & bus.dividend[DATA_W-1];
  assign b_neg = (bus.is_signed == DIV_SIGNED)
               & bus.divisor[DATA_W-1];
  assign a_abs = a_neg ? -bus.dividend
                       : bus.dividend;
  assign b_abs = b_neg ? -bus.divisor
                       : bus.divisor;

  // Trial subtract; low bits of the difference
  // are exact whenever the compare says it fits.
  assign part  = {rem_q, dvd_q[DATA_W-1]};
  assign sub   = part[DATA_W-1:0] - dvs_q;
  assign take  = part >= {1'b0, dvs_q};
  assign q_nxt = {dvd_q[DATA_W-2:0], take};
  assign r_nxt = take ? sub : part[DATA_W-1:0];
  assign q_fix = neg_q ? -q_nxt : q_nxt;
  assign r_fix = neg_r ? -r_nxt : r_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= DIV_FREE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.cancel) begin
        state  <= DIV_FREE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          DIV_FREE: begin
            if (bus.start == DIV_START) begin
              busy_q <= 1'b1;
              if (bus.divisor == '0) begin
                state   <= DIV_END;
                quo_q   <= '1;
                rmd_q   <= bus.dividend;
                valid_q <= 1'b1;
              end else begin
                state <= DIV_ON;
                cnt_q <= '0;
                dvd_q <= a_abs;
                dvs_q <= b_abs;
                rem_q <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
              end
            end
          end
          DIV_ON: begin
            dvd_q <= q_nxt;
            rem_q <= r_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state   <= DIV_END;
              quo_q   <= q_fix;
              rmd_q   <= r_fix;
              valid_q <= 1'b1;
            end
          end
          DIV_END: begin
            state  <= DIV_FREE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= DIV_FREE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;

endmodule
